// File: rtl/ring_dec_pkg.sv
// Shared types and defaults for the ring phase decoder.
package ring_dec_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    localparam int        DEF_WIDTH    = 8;
    localparam int        DEF_LOCK_CNT = 4;
    localparam logic [7:0] ERRCNT_MAX  = 8'hFF;

endpackage

// File: rtl/ring_phase_decoder_onehot_enc.sv
// Combinational one-hot detector and encoder. pos is an OR of the indices of
// all set bits, so it is only meaningful when onehot is 1.
module onehot_enc #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic             o_onehot,
    output logic [IDXW-1:0]  o_pos
);

    logic [WIDTH-1:0] w_low_cleared;

    assign w_low_cleared = i_vec & (i_vec - WIDTH'(1));
    assign o_onehot      = (i_vec != '0) && (w_low_cleared == '0);

    // OR together the indices of all set bits (no priority chain).
    always_comb begin
        o_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) o_pos = o_pos | IDXW'(i);
        end
    end

endmodule

// File: rtl/ring_phase_decoder.sv
// Ring phase decoder: encodes a rotating one-hot vector to a phase index,
// checks single-step advance, and runs a SEARCH/LOCKED/FAULT lock machine.
// Optional saturating error counter enabled by defining RING_DEC_ERRCNT_EN;
// otherwise err_cnt is tied to 0.
module ring_phase_decoder
    import ring_dec_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int IDXW     = $clog2(WIDTH),
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk,
    input  logic             init,
    input  logic             en,
    input  logic [WIDTH-1:0] ring_in,
    output logic [IDXW-1:0]  idx,
    output logic             valid,
    output logic             locked,
    output logic             fault,
    output logic             err,
    output logic             wrap,
    output logic [7:0]       err_cnt
);

    localparam int RUNW = (LOCK_CNT + 1 > 2) ? $clog2(LOCK_CNT + 1) : 1;

    state_t           r_state, w_state_nxt;
    logic [RUNW-1:0]  r_run, w_run_nxt;
    logic             r_have_prev, w_have_prev_nxt;
    logic [IDXW-1:0]  r_prev_pos;
    logic [IDXW-1:0]  r_idx;
    logic             r_valid, r_err, r_wrap;
    logic             w_onehot, w_correct, w_err_nxt, w_prev_last;
    logic [IDXW-1:0]  w_pos, w_expect;

    onehot_enc #(.WIDTH(WIDTH), .IDXW(IDXW)) u_enc (
        .i_vec    (ring_in),
        .o_onehot (w_onehot),
        .o_pos    (w_pos)
    );

    assign w_prev_last = (r_prev_pos == IDXW'(WIDTH - 1));
    assign w_expect    = w_prev_last ? '0 : r_prev_pos + IDXW'(1);
    assign w_correct   = w_onehot && r_have_prev && (w_pos == w_expect);

    // Next state, run counter and reference bookkeeping for one en sample.
    always_comb begin
        w_state_nxt     = r_state;
        w_run_nxt       = r_run;
        w_have_prev_nxt = r_have_prev;
        w_err_nxt       = 1'b0;
        if (en) begin
            case (r_state)
                SEARCH: begin
                    if (w_correct) begin
                        if (r_run == RUNW'(LOCK_CNT - 1)) begin
                            w_state_nxt = LOCKED;
                            w_run_nxt   = '0;
                        end else begin
                            w_run_nxt = r_run + RUNW'(1);
                        end
                    end else begin
                        w_run_nxt = '0;
                        if (!w_onehot) w_have_prev_nxt = 1'b0;
                    end
                end
                LOCKED: begin
                    if (!w_correct) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = FAULT;
                    end
                end
                FAULT: begin
                    if (w_onehot) begin
                        w_state_nxt = SEARCH;
                        w_run_nxt   = '0;
                    end
                end
                default: w_state_nxt = SEARCH;
            endcase
            // Any one-hot sample becomes the reference for the next step.
            if (w_onehot) w_have_prev_nxt = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (init) r_state <= SEARCH;
        else      r_state <= w_state_nxt;
    end

    // Datapath and output registers; err/wrap are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (init) begin
            r_run       <= '0;
            r_have_prev <= 1'b0;
            r_prev_pos  <= '0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_run       <= w_run_nxt;
            r_have_prev <= w_have_prev_nxt;
            r_err       <= w_err_nxt;
            r_wrap      <= en && w_correct && w_prev_last;
            if (en) begin
                r_valid <= w_onehot;
                if (w_onehot) begin
                    r_idx      <= w_pos;
                    r_prev_pos <= w_pos;
                end
            end
        end
    end

`ifdef RING_DEC_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of err pulses.
    always_ff @(posedge clk) begin
        if (init)                                  r_err_cnt <= '0;
        else if (w_err_nxt && r_err_cnt != ERRCNT_MAX) r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

    assign idx    = r_idx;
    assign valid  = r_valid;
    assign locked = (r_state == LOCKED);
    assign fault  = (r_state == FAULT);
    assign err    = r_err;
    assign wrap   = r_wrap;

endmodule

// File: doc/ring_phase_decoder.md
# ring_phase_decoder

Receive-side companion to the one-hot ring counter. Samples an N-bit rotating one-hot vector on a strobe and encodes it to a binary phase index. Checks that each sample is strictly one-hot and advances by exactly one position (bit k → bit k+1, MSB → bit 0). Runs a lock/fault state machine, so downstream logic receives a trusted phase index plus error and wrap events.

## Interface
- WIDTH, 8, ring width in bits (≥2)
- IDXW, $clog2(WIDTH), index width
- LOCK_CNT, 4, consecutive correct steps required to lock (≥1)
- clk  input  1  rising-edge clock
- init  input  1  synchronous active-high reset; overrides all other inputs
- en  input  1  sample strobe; ring_in is evaluated only on cycles with en=1
- ring_in  input  WIDTH  ring-counter vector under test
- idx  output  IDXW  index of last valid one-hot sample
- valid  output  1  last evaluated sample was one-hot
- locked  output  1  state LOCKED
- fault  output  1  state FAULT
- err  output  1  one-cycle pulse: bad sample while LOCKED
- wrap  output  1  one-cycle pulse: correct step from WIDTH-1 to 0
- err_cnt  output  8  saturating error count (see Configuration)

## Operation
- Reset (init=1 at edge): idx=0, valid=0, locked=0, fault=0, err=0, wrap=0, err_cnt=0, state=SEARCH, run=0, have_prev=0.
- en=0: all state and level outputs hold; err and wrap are 0.
- Per en sample: onehot = exactly one bit set. pos = index of that bit. correct = onehot && have_prev && pos == (prev_pos+1) mod WIDTH.
- Valid sample: idx←pos, valid←1, prev_pos←pos, have_prev←1. Invalid sample: valid←0; idx and prev_pos hold.
- States:
  - SEARCH:
    - correct → run+1; if run+1 == LOCK_CNT → LOCKED, run←0.
    - onehot but not correct → run←0; the sample becomes the new reference.
    - not onehot → run←0, have_prev←0.
  - LOCKED:
    - correct → stay.
    - not correct (including not onehot) → err pulse, FAULT.
  - FAULT:
    - onehot → SEARCH, run←0; the sample is the reference.
    - else stay.
- wrap pulses on any correct step with prev_pos=WIDTH-1 and pos=0, in any state.
- No err in SEARCH or FAULT.

## Timing
- All outputs are registered. The response appears the cycle after the en edge that samples ring_in.
- Lock latency: LOCK_CNT+1 valid samples after reset or FAULT exit. locked rises at the edge that processes the LOCK_CNT-th correct step.
- err, fault=1, and locked=0 all take effect on the same edge.
- init together with en: init wins and the sample is discarded.
- init mid-lock: return to the reset values at the next edge.
- A single sample cannot produce both err and wrap, because wrap requires a correct step.

## Configuration
- RING_DEC_ERRCNT_EN defined: err_cnt increments on every err pulse and saturates at 255 (no wrap). init clears it.
- Not defined: the err_cnt port remains and is tied to 0. No counter flops are synthesized.

## Structure
- Package ring_dec_pkg holds:
  - state enum {SEARCH, LOCKED, FAULT}
  - default parameter constants (WIDTH, LOCK_CNT)
  - ERRCNT_MAX = 8'hFF
- Sub-module onehot_enc: combinational, WIDTH→{onehot, pos}; a priority-free encode that is valid only when onehot=1. The top instantiates it once.
- The top contains the FSM, run counter, prev_pos/have_prev registers, output registers, and the optional error counter.

## Test plan
- WIDTH=8, LOCK_CNT=4: init, then en samples 0x80,0x01,0x02,0x04,0x08 → wrap=1 after 0x01; locked=1 after 0x08; idx=3, valid=1.
- Locked at idx=3; sample 0x18 → err pulse, fault=1, locked=0, valid=0, idx=3, err_cnt=1. Next sample 0x20 → SEARCH, idx=5, no err.
- Locked after 0x04; sample 0x10 (skip) → err, fault=1, idx=4.
- en=0 for 10 cycles while ring_in toggles randomly → every output unchanged; err=wrap=0.
- Locked; init=1 with en=1 and ring_in=0x10 → next cycle idx=0, valid=0, locked=0, fault=0, err_cnt=0.
- Alternate a bad sample with 5 correct samples, 300 times, with the macro on → err_cnt=255. Same stimulus with the macro off → err_cnt=0.
